// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with data-memory handshake tracking, load alignment
// and register-file write port; the registered WB fields also feed forwarding.
package regfilemux;
    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8,
        store    = 4'd9
    } regfilemux_sel_t;
endpackage

module mem_wb_writeback (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_valid,
    input  logic                        mem_flush,
    input  logic                        stall_in,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [4:0]                  mem_rd,
    input  regfilemux::regfilemux_sel_t mem_regfile_sel,
    input  logic [31:0]                 mem_alu_out,
    input  logic [31:0]                 mem_u_imm,
    input  logic [31:0]                 mem_pc,
    input  logic                        mem_br_en,
    input  logic                        dmem_resp,
    input  logic [31:0]                 dmem_rdata,
    output logic                        mem_stall,
    output logic                        load_regfile,
    output logic [4:0]                  regfile_rd,
    output logic [31:0]                 regfile_in,
    output logic [4:0]                  MEM_WB_rd,
    output regfilemux::regfilemux_sel_t MEM_WB_regfile_sel,
    output logic [31:0]                 MEM_WB_alu_out,
    output logic [31:0]                 MEM_WB_mem_out,
    output logic [31:0]                 pc_wb,
    output logic [31:0]                 u_imm_wb,
    output logic                        flush_mem_wb,
    output logic [63:0]                 instret
);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_t;

    state_t                      state_q, state_d;
    logic                        squashed_q, squashed_d;
    logic                        buf_vld_q, buf_vld_d;
    logic [31:0]                 buf_q, buf_d;
    logic                        wb_valid_q;
    logic                        br_en_wb_q;
    logic [4:0]                  rd_q;
    regfilemux::regfilemux_sel_t sel_q;
    logic [31:0]                 alu_q, mem_out_q, pc_q, u_imm_q;
    logic [63:0]                 instret_q;

    logic        access, resp_live, advance;
    logic [31:0] mem_word, shifted, load_data;
    logic [15:0] half;

    // A buffered response or a squashed instruction no longer needs the memory.
    assign access    = mem_valid & (mem_read | mem_write) & ~squashed_q & ~buf_vld_q;
    assign resp_live = dmem_resp & ((state_q == S_WAIT) | ((state_q == S_RUN) & access));
    assign advance   = ~mem_stall & ~stall_in;
    assign mem_word  = buf_vld_q ? buf_q : dmem_rdata;

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            S_RUN: begin
                if (access & ~dmem_resp) begin
                    mem_stall = 1'b1;
                    state_d   = mem_flush ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_resp) begin
                    state_d = S_RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (mem_flush) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                mem_stall = 1'b1;
                if (dmem_resp) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // A flush that cannot advance yet is remembered until the slot moves on.
    always_comb begin
        squashed_d = advance ? 1'b0 : (squashed_q | mem_flush);
        buf_vld_d  = advance ? 1'b0 : (buf_vld_q | resp_live);
        buf_d      = (resp_live & ~buf_vld_q) ? dmem_rdata : buf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_RUN;
            squashed_q <= 1'b0;
            buf_vld_q  <= 1'b0;
            buf_q      <= '0;
            wb_valid_q <= 1'b0;
            br_en_wb_q <= 1'b0;
            rd_q       <= '0;
            sel_q      <= regfilemux::alu_out;
            alu_q      <= '0;
            mem_out_q  <= '0;
            pc_q       <= '0;
            u_imm_q    <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            squashed_q <= squashed_d;
            buf_vld_q  <= buf_vld_d;
            buf_q      <= buf_d;
            if (advance) begin
                wb_valid_q <= mem_valid & ~mem_flush & ~squashed_q;
                br_en_wb_q <= mem_br_en;
                rd_q       <= mem_rd;
                sel_q      <= mem_regfile_sel;
                alu_q      <= mem_alu_out;
                mem_out_q  <= mem_word;
                pc_q       <= mem_pc;
                u_imm_q    <= mem_u_imm;
                if (wb_valid_q) instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign shifted = mem_out_q >> {alu_q[1:0], 3'b000};
    assign half    = alu_q[1] ? mem_out_q[31:16] : mem_out_q[15:0];

    always_comb begin
        load_data = mem_out_q;
        case (sel_q)
            regfilemux::lb:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            regfilemux::lbu: load_data = {24'b0, shifted[7:0]};
            regfilemux::lh:  load_data = {{16{half[15]}}, half};
            regfilemux::lhu: load_data = {16'b0, half};
            default:         load_data = mem_out_q;
        endcase
    end

    always_comb begin
        regfile_in = alu_q;
        case (sel_q)
            regfilemux::br_en:    regfile_in = {31'b0, br_en_wb_q};
            regfilemux::u_imm:    regfile_in = u_imm_q;
            regfilemux::pc_plus4: regfile_in = pc_q + 32'd4;
            regfilemux::lw, regfilemux::lb, regfilemux::lbu,
            regfilemux::lh, regfilemux::lhu: regfile_in = load_data;
            default:              regfile_in = alu_q;
        endcase
    end

    assign load_regfile       = wb_valid_q & (rd_q != 5'd0) & (sel_q != regfilemux::store);
    assign regfile_rd         = rd_q;
    assign MEM_WB_rd          = rd_q;
    assign MEM_WB_regfile_sel = sel_q;
    assign MEM_WB_alu_out     = alu_q;
    assign MEM_WB_mem_out     = mem_out_q;
    assign pc_wb              = pc_q;
    assign u_imm_wb           = u_imm_q;
    assign flush_mem_wb       = ~wb_valid_q;
    assign instret            = instret_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: inputs change and outputs are sampled on
// the falling edge, expected values are hand-computed constants.
module tb_mem_wb_writeback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mem_valid, mem_flush, stall_in, mem_read, mem_write, mem_br_en, dmem_resp;
    logic [4:0]  mem_rd;
    regfilemux::regfilemux_sel_t mem_regfile_sel, MEM_WB_regfile_sel;
    logic [31:0] mem_alu_out, mem_u_imm, mem_pc, dmem_rdata;
    logic        mem_stall, load_regfile, flush_mem_wb;
    logic [4:0]  regfile_rd, MEM_WB_rd;
    logic [31:0] regfile_in, MEM_WB_alu_out, MEM_WB_mem_out, pc_wb, u_imm_wb;
    logic [63:0] instret;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] exp_ret = '0;

    mem_wb_writeback dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_flush(mem_flush),
        .stall_in(stall_in), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rd(mem_rd), .mem_regfile_sel(mem_regfile_sel),
        .mem_alu_out(mem_alu_out), .mem_u_imm(mem_u_imm), .mem_pc(mem_pc),
        .mem_br_en(mem_br_en), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .load_regfile(load_regfile), .regfile_rd(regfile_rd),
        .regfile_in(regfile_in), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_regfile_sel(MEM_WB_regfile_sel), .MEM_WB_alu_out(MEM_WB_alu_out),
        .MEM_WB_mem_out(MEM_WB_mem_out), .pc_wb(pc_wb), .u_imm_wb(u_imm_wb),
        .flush_mem_wb(flush_mem_wb), .instret(instret)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        mem_valid = 0; mem_flush = 0; stall_in = 0; mem_read = 0; mem_write = 0;
        mem_rd = 0; mem_regfile_sel = regfilemux::alu_out; mem_alu_out = 0;
        mem_u_imm = 0; mem_pc = 0; mem_br_en = 0; dmem_resp = 0;
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [4:0] rd,
                         input regfilemux::regfilemux_sel_t sel, input logic [31:0] alu,
                         input logic [31:0] uimm, input logic [31:0] pc, input logic br);
        mem_valid = 1; mem_read = rd_en; mem_write = wr_en; mem_rd = rd;
        mem_regfile_sel = sel; mem_alu_out = alu; mem_u_imm = uimm; mem_pc = pc; mem_br_en = br;
    endtask

    task automatic nonmem(input string tag, input logic [4:0] rd,
                          input regfilemux::regfilemux_sel_t sel, input logic [31:0] alu,
                          input logic [31:0] uimm, input logic [31:0] pc, input logic br,
                          input logic [31:0] exp_in, input logic exp_ld);
        drive(0, 0, rd, sel, alu, uimm, pc, br);
        #1 chk({tag, "_stall"}, mem_stall, 0);
        cyc(); idle();
        chk({tag, "_ld"}, load_regfile, exp_ld);
        chk({tag, "_in"}, regfile_in, exp_in);
        chk({tag, "_valid"}, flush_mem_wb, 0);
        exp_ret++;
        cyc();
        chk({tag, "_ret"}, instret, exp_ret);
    endtask

    task automatic load(input string tag, input regfilemux::regfilemux_sel_t sel,
                        input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] rd,
                        input int wait_n, input logic [31:0] exp_in);
        drive(1, 0, rd, sel, alu, 0, 0, 0);
        for (int i = 0; i < wait_n; i++) begin
            #1 chk({tag, "_stall_hi"}, mem_stall, 1);
            cyc();
        end
        dmem_resp = 1; dmem_rdata = rdata;
        #1 chk({tag, "_stall_lo"}, mem_stall, 0);
        cyc(); idle();
        chk({tag, "_ld"}, load_regfile, 1);
        chk({tag, "_rd"}, regfile_rd, rd);
        chk({tag, "_in"}, regfile_in, exp_in);
        exp_ret++;
        cyc();
        chk({tag, "_ret"}, instret, exp_ret);
    endtask

    initial begin
        rst = 0; dmem_rdata = 0; idle();
        cyc(); cyc();
        chk("rst_stall", mem_stall, 0);
        chk("rst_ld", load_regfile, 0);
        chk("rst_rd", regfile_rd, 0);
        chk("rst_in", regfile_in, 0);
        chk("rst_flush", flush_mem_wb, 1);
        chk("rst_ret", instret, 0);
        chk("rst_alu", MEM_WB_alu_out, 0);
        chk("rst_memout", MEM_WB_mem_out, 0);
        chk("rst_pc", pc_wb, 0);
        chk("rst_uimm", u_imm_wb, 0);
        rst = 1;
        cyc();

        nonmem("alu", 5'd5, regfilemux::alu_out, 32'h1234, 0, 0, 0, 32'h1234, 1);
        nonmem("bren", 5'd4, regfilemux::br_en, 32'h55, 0, 0, 1, 32'h1, 1);
        nonmem("uimm", 5'd2, regfilemux::u_imm, 0, 32'hABCD_E000, 0, 0, 32'hABCD_E000, 1);
        nonmem("jal_x0", 5'd0, regfilemux::pc_plus4, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 0);

        load("lb", regfilemux::lb, 32'h103, 32'h80FF_FF7F, 5'd3, 3, 32'hFFFF_FF80);
        load("lbu", regfilemux::lbu, 32'h103, 32'h80FF_FF7F, 5'd3, 0, 32'h0000_0080);
        load("lh", regfilemux::lh, 32'h102, 32'h8001_0002, 5'd8, 1, 32'hFFFF_8001);
        load("lhu", regfilemux::lhu, 32'h102, 32'h8001_0002, 5'd8, 0, 32'h0000_8001);
        load("lw", regfilemux::lw, 32'h100, 32'h1357_9BDF, 5'd10, 2, 32'h1357_9BDF);

        // store retires but never writes the register file
        drive(0, 1, 5'd6, regfilemux::store, 32'h40, 0, 0, 0);
        dmem_resp = 1;
        #1 chk("st_stall", mem_stall, 0);
        cyc(); idle();
        chk("st_ld", load_regfile, 0);
        chk("st_valid", flush_mem_wb, 0);
        exp_ret++;
        cyc();
        chk("st_ret", instret, exp_ret);

        // flush while waiting on a load to x7
        drive(1, 0, 5'd7, regfilemux::lw, 32'h200, 0, 0, 0);
        #1 chk("fl_stall0", mem_stall, 1);
        cyc(); mem_flush = 1;
        #1 chk("fl_stall1", mem_stall, 1);
        cyc(); mem_flush = 0;
        #1 chk("fl_stall2", mem_stall, 1);
        cyc(); dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("fl_stall3", mem_stall, 1);
        cyc(); dmem_resp = 0;
        #1 chk("fl_stall4", mem_stall, 0);
        cyc(); idle();
        chk("fl_ld", load_regfile, 0);
        chk("fl_flush", flush_mem_wb, 1);
        cyc();
        chk("fl_ret", instret, exp_ret);

        // response arrives under an external stall; data must survive in the buffer
        drive(1, 0, 5'd9, regfilemux::lw, 32'h300, 0, 0, 0);
        #1 chk("sb_stall0", mem_stall, 1);
        cyc(); dmem_resp = 1; dmem_rdata = 32'hCAFE_F00D; stall_in = 1;
        #1 chk("sb_stall1", mem_stall, 0);
        cyc(); dmem_resp = 0; dmem_rdata = 32'h0;
        #1 chk("sb_stall2", mem_stall, 0);
        chk("sb_hold_ld", load_regfile, 0);
        cyc();
        chk("sb_hold_ld2", load_regfile, 0);
        stall_in = 0;
        cyc(); idle();
        chk("sb_ld", load_regfile, 1);
        chk("sb_rd", regfile_rd, 9);
        chk("sb_in", regfile_in, 32'hCAFE_F00D);
        exp_ret++;
        cyc();
        chk("sb_ret", instret, exp_ret);

        // reset in the middle of a wait, then a stale response
        drive(1, 0, 5'd11, regfilemux::lw, 32'h400, 0, 0, 0);
        cyc(); rst = 0;
        cyc(); idle();
        cyc();
        chk("rw_ld", load_regfile, 0);
        chk("rw_flush", flush_mem_wb, 1);
        chk("rw_ret", instret, 0);
        chk("rw_rd", regfile_rd, 0);
        chk("rw_in", regfile_in, 0);
        rst = 1; dmem_resp = 1; dmem_rdata = 32'h7777_7777;
        #1 chk("rw_stall", mem_stall, 0);
        cyc(); dmem_resp = 0;
        #1 chk("rw_stall2", mem_stall, 0);
        chk("rw_ld2", load_regfile, 0);
        chk("rw_flush2", flush_mem_wb, 1);
        chk("rw_ret2", instret, 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
